// File: rtl/loader_pkg.sv
// Shared constants and state encoding for the instruction loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RECEIVE = 3'd1;
    localparam logic [2:0] ST_WRITE   = 3'd2;
    localparam logic [2:0] ST_DONE    = 3'd3;
    localparam logic [2:0] ST_CHECK   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_RECEIVE = ST_RECEIVE,
        S_WRITE   = ST_WRITE,
        S_DONE    = ST_DONE,
        S_CHECK   = ST_CHECK
    } state_t;

endpackage

// File: rtl/instruction_loader_if.sv
// Byte stream in from the UART receiver and write port out to instruction memory.
// Latency: n/a (signal bundle only).
// Backpressure: none; rx_valid is a one-cycle strobe that must be taken when offered.
// Modports: master = loader (consumes rx, drives write port);
//           slave  = environment (drives rx, consumes write port).
interface instruction_loader_if #(
    parameter int NB_ADDR      = 6,
    parameter int MEMORY_WIDTH = 32
);
    logic [7:0]              rx_data;
    logic                    rx_valid;
    logic [NB_ADDR-1:0]      write_addr;
    logic [MEMORY_WIDTH-1:0] write_data;
    logic                    write_enable;

    modport master (
        input  rx_data,
        input  rx_valid,
        output write_addr,
        output write_data,
        output write_enable
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  write_addr,
        input  write_data,
        input  write_enable
    );
endinterface

// File: rtl/word_assembler.sv
// Packs a byte stream into 32-bit big-endian words (first byte lands in the MSB).
// Latency: o_word_ready pulses combinationally with the 4th byte; o_word is valid the next cycle.
// Backpressure: none; every i_byte_valid is taken.
// Ports: i_clock, i_reset (async high), i_clear (sync restart), i_byte_valid/i_byte in;
//        o_word (shift register contents), o_word_ready (4th byte being accepted).
module word_assembler
    import loader_pkg::*;
(
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_ready
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [31:0] r_shift;
    logic [1:0]  r_count;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (i_byte_valid) begin
            r_shift <= {r_shift[23:0], i_byte};
            // Two-bit counter wraps to 0 after the 4th byte, ready for the next word.
            r_count <= r_count + 2'd1;
        end
    end

    assign o_word       = r_shift;
    assign o_word_ready = i_byte_valid && !i_clear && (r_count == LAST_BYTE);

endmodule

// File: rtl/instruction_loader.sv
// Loads a program from the UART byte stream into instruction memory, one 32-bit word per write.
// Latency: write strobe one cycle after the 4th byte of each word; stops on HALT word or full memory.
// Backpressure: none; bytes are accepted in RECEIVE and in a non-final WRITE cycle, ignored elsewhere.
// Ports: i_clock, i_reset (async high), i_start; io_bus (rx byte stream in, memory write port out);
//        o_busy, o_done, o_word_count, o_checksum_error status out.
// Optional: define LOADER_CHECKSUM_EN to verify a trailing XOR checksum byte.
module instruction_loader
    import loader_pkg::*;
#(
    parameter int                      MEMORY_WIDTH = 32,
    parameter int                      MEMORY_DEPTH = 64,
    parameter int                      NB_ADDR      = 6,
    parameter logic [MEMORY_WIDTH-1:0] HALT_WORD    = DEFAULT_HALT_WORD
)(
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    instruction_loader_if.master io_bus,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [NB_ADDR:0]     o_word_count,
    output logic                 o_checksum_error
);

    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(MEMORY_DEPTH - 1);

    state_t                   r_state;
    state_t                   w_next_state;
    logic [NB_ADDR-1:0]       r_addr;
    logic [NB_ADDR:0]         r_word_count;
    logic                     w_start_load;
    logic                     w_asm_valid;
    logic                     w_last_word;
    logic                     w_word_ready;
    logic [MEMORY_WIDTH-1:0]  w_word;

    word_assembler u_word_assembler (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_clear      (w_start_load),
        .i_byte_valid (w_asm_valid),
        .i_byte       (io_bus.rx_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    // The word being written is final when it is HALT or fills the last entry.
    assign w_last_word = (w_word == HALT_WORD) || (r_addr == LAST_ADDR);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_start_load = 1'b0;
        w_asm_valid  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_start_load = 1'b1;
                    w_next_state = S_RECEIVE;
                end
            end
            S_RECEIVE: begin
                w_asm_valid = io_bus.rx_valid;
                if (w_word_ready) begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    w_next_state = S_CHECK;
`else
                    w_next_state = S_DONE;
`endif
                end else begin
                    // A byte landing during the write is the first byte of the next word.
                    w_asm_valid  = io_bus.rx_valid;
                    w_next_state = S_RECEIVE;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (io_bus.rx_valid) begin
                    w_next_state = S_DONE;
                end
            end
`endif
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_addr       <= '0;
            r_word_count <= '0;
        end else if (w_start_load) begin
            r_addr       <= '0;
            r_word_count <= '0;
        end else if (r_state == S_WRITE) begin
            r_word_count <= r_word_count + (NB_ADDR+1)'(1);
            // Address holds on the final word so it never wraps back to 0.
            if (!w_last_word) begin
                r_addr <= r_addr + NB_ADDR'(1);
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_xor;
    logic       r_checksum_error;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_xor            <= '0;
            r_checksum_error <= 1'b0;
        end else if (w_start_load) begin
            r_xor            <= '0;
            r_checksum_error <= 1'b0;
        end else begin
            if (w_asm_valid) begin
                r_xor <= r_xor ^ io_bus.rx_data;
            end
            if ((r_state == S_CHECK) && io_bus.rx_valid) begin
                r_checksum_error <= (io_bus.rx_data != r_xor);
            end
        end
    end

    assign o_checksum_error = r_checksum_error;
`else
    assign o_checksum_error = 1'b0;
`endif

    // All outputs decode registered state, so they are glitch-free and 0 in reset.
    assign io_bus.write_enable = (r_state == S_WRITE);
    assign io_bus.write_addr   = r_addr;
    assign io_bus.write_data   = w_word;
    assign o_busy              = (r_state == S_RECEIVE) || (r_state == S_WRITE) || (r_state == S_CHECK);
    assign o_done              = (r_state == S_DONE);
    assign o_word_count        = r_word_count;

endmodule
